// File: rtl/fc_if.sv
// Handshake bundle between the program-storage stage, fc_stage and the
// function-processing stage.
interface fc_if #(
   parameter int unsigned IDX_W = 4
) ();
   logic                Send_in;
   logic                DEL;
   logic [61:0]         PACKET_IN;
   logic                Ack_out;
   logic                Send_out;
   logic                Ack_in;
   logic [91:0]         PACKET_OUT;
   logic                RETRY;
   logic [IDX_W:0]      OCC;

   modport master (
      output Send_in, DEL, PACKET_IN, Ack_in,
      input  Ack_out, Send_out, PACKET_OUT, RETRY, OCC
   );

   modport slave (
      input  Send_in, DEL, PACKET_IN, Ack_in,
      output Ack_out, Send_out, PACKET_OUT, RETRY, OCC
   );
endinterface

// File: rtl/fc_stage.sv
// Firing-control stage: passes monadic packets, pairs dyadic operands in a
// direct-mapped matching memory and emits fired or retry packets.
module fc_stage #(
   parameter int unsigned IDX_W = 4
) (
   input logic  CP,
   input logic  MR,
   fc_if.slave  bus
);
   localparam int unsigned DEPTH = 1 << IDX_W;
   localparam int unsigned OCC_W = IDX_W + 1;

   logic [DEPTH-1:0] v_q;
   logic [27:0]      tag_q  [DEPTH];
   logic [DEPTH-1:0] lr_q;
   logic [31:0]      data_q [DEPTH];
   logic [OCC_W-1:0] occ_q, occ_d;

   logic        send_q;
   logic [91:0] pkt_q, pkt_d;
   logic        retry_q, retry_d;
   logic        load;
   logic        wr_set, wr_clr;

   logic             accept;
   logic [27:0]      in_tag;
   logic [31:0]      in_data;
   logic             in_lr;
   logic             dyadic;
   logic [IDX_W-1:0] idx;
   logic             unused_rsvd;

   assign in_tag      = bus.PACKET_IN[61:34];
   assign in_data     = bus.PACKET_IN[31:0];
   assign in_lr       = bus.PACKET_IN[33];
   assign dyadic      = bus.PACKET_IN[40];
   assign unused_rsvd = bus.PACKET_IN[32];
   // Index hashes the low bits of colour and next-destination together.
   assign idx         = bus.PACKET_IN[51 +: IDX_W] ^ bus.PACKET_IN[44 +: IDX_W];

   assign bus.Ack_out    = !MR && (!send_q || bus.Ack_in);
   assign accept         = bus.Send_in && bus.Ack_out;
   assign bus.Send_out   = send_q;
   assign bus.PACKET_OUT = pkt_q;
   assign bus.RETRY      = retry_q;
   assign bus.OCC        = occ_q;

   always_comb begin
      load    = 1'b0;
      pkt_d   = '0;
      retry_d = 1'b0;
      wr_set  = 1'b0;
      wr_clr  = 1'b0;
      occ_d   = occ_q;
      if (accept && bus.DEL) begin
         if (!dyadic) begin
            load  = 1'b1;
            pkt_d = {in_tag, in_data, 32'd0};
         end else if (!v_q[idx]) begin
            wr_set = 1'b1;
            occ_d  = occ_q + OCC_W'(1);
         end else if (tag_q[idx] == in_tag && lr_q[idx] != in_lr) begin
            load   = 1'b1;
            wr_clr = 1'b1;
            occ_d  = occ_q - OCC_W'(1);
            pkt_d  = in_lr ? {in_tag, data_q[idx], in_data}
                           : {in_tag, in_data, data_q[idx]};
         end else begin
            load    = 1'b1;
            retry_d = 1'b1;
            pkt_d   = {in_tag, in_data, 31'd0, in_lr};
         end
      end
   end

   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         send_q  <= 1'b0;
         pkt_q   <= '0;
         retry_q <= 1'b0;
         occ_q   <= '0;
         v_q     <= '0;
      end else begin
         occ_q <= occ_d;
         if (wr_set) v_q[idx] <= 1'b1;
         if (wr_clr) v_q[idx] <= 1'b0;
         if (load) begin
            send_q  <= 1'b1;
            pkt_q   <= pkt_d;
            retry_q <= retry_d;
         end else if (bus.Ack_in) begin
            send_q <= 1'b0;
         end
      end
   end

   // Payload needs no reset: it is only read behind a set valid bit.
   always_ff @(posedge CP) begin
      if (wr_set) begin
         tag_q[idx]  <= in_tag;
         lr_q[idx]   <= in_lr;
         data_q[idx] <= in_data;
      end
   end
endmodule

// File: tb/tb_fc_stage.sv
// Scoreboard bench for fc_stage: directed packets, expectations queued at
// acceptance and checked by an independent output monitor.
module tb_fc_stage;
   logic CP = 1'b0;
   logic MR = 1'b1;
   always #5 CP = ~CP;

   fc_if #(.IDX_W(4)) bus ();
   fc_stage #(.IDX_W(4)) dut (.CP(CP), .MR(MR), .bus(bus));

   typedef struct packed {
      logic [91:0] pkt;
      logic        retry;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [61:0] mk(input logic [10:0] cg, input logic [6:0] nxt,
                                      input logic [3:0] flg, input logic [5:0] opc,
                                      input logic lr, input logic [31:0] data);
      return {cg, nxt, flg, opc, lr, 1'b0, data};
   endfunction

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic send(input logic del, input logic [61:0] pkt, input logic has_exp,
                       input logic [91:0] ep, input logic er);
      logic acc;
      int   n;
      bus.Send_in   = 1'b1;
      bus.DEL       = del;
      bus.PACKET_IN = pkt;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         @(negedge CP);
         acc = bus.Ack_out;
         @(posedge CP);
         #1;
         n++;
      end
      if (!acc) begin
         n_vec++;
         n_bad++;
         $display("FAIL send_timeout: got no accept, expected accept of %h", pkt);
      end else if (has_exp) begin
         exp_q.push_back('{pkt: ep, retry: er});
      end
   endtask

   task automatic idle();
      bus.Send_in = 1'b0;
   endtask

   // Monitor: one output transfer happens at the next rising edge.
   always @(negedge CP) begin
      if (!MR && bus.Send_out && bus.Ack_in) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: got %h retry %b, expected none",
                     bus.PACKET_OUT, bus.RETRY);
         end else begin
            e = exp_q.pop_front();
            if ({bus.PACKET_OUT, bus.RETRY} !== {e.pkt, e.retry}) begin
               n_bad++;
               $display("FAIL output: got %h retry %b, expected %h retry %b",
                        bus.PACKET_OUT, bus.RETRY, e.pkt, e.retry);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [61:0] p, q;
      bus.Send_in   = 1'b0;
      bus.DEL       = 1'b0;
      bus.PACKET_IN = '0;
      bus.Ack_in    = 1'b0;

      // Reset state
      #2;
      chk("rst_ack_out", 96'(bus.Ack_out), 96'd0);
      chk("rst_send_out", 96'(bus.Send_out), 96'd0);
      chk("rst_packet_out", 96'(bus.PACKET_OUT), 96'd0);
      chk("rst_occ", 96'(bus.OCC), 96'd0);
      #10 MR = 1'b0;
      @(posedge CP);
      #1;
      chk("rel_ack_out", 96'(bus.Ack_out), 96'd1);
      bus.Ack_in = 1'b1;

      // Monadic pass-through, then absorbed packet
      p = mk(11'h010, 7'h02, 4'b0000, 6'h05, 1'b0, 32'h0000_0005);
      send(1'b1, p, 1'b1, {p[61:34], 32'h0000_0005, 32'd0}, 1'b0);
      chk("mono_valid", 96'(bus.Send_out), 96'd1);
      q = mk(11'h010, 7'h02, 4'b0000, 6'h05, 1'b0, 32'h0000_0009);
      send(1'b0, q, 1'b0, '0, 1'b0);
      chk("absorb_no_output", 96'(bus.Send_out), 96'd0);
      idle();

      // Pair, right operand first
      p = mk(11'h020, 7'h03, 4'b0001, 6'h0A, 1'b1, 32'd7);
      send(1'b1, p, 1'b0, '0, 1'b0);
      chk("pair_r_occ", 96'(bus.OCC), 96'd1);
      chk("pair_r_no_out", 96'(bus.Send_out), 96'd0);
      q = mk(11'h020, 7'h03, 4'b0001, 6'h0A, 1'b0, 32'd3);
      send(1'b1, q, 1'b1, {q[61:34], 32'd3, 32'd7}, 1'b0);
      chk("pair_fire_occ", 96'(bus.OCC), 96'd0);
      idle();

      // Back-to-back L then R
      p = mk(11'h044, 7'h05, 4'b0001, 6'h11, 1'b0, 32'hAAAA_0001);
      send(1'b1, p, 1'b0, '0, 1'b0);
      chk("b2b_l_occ", 96'(bus.OCC), 96'd1);
      q = mk(11'h044, 7'h05, 4'b0001, 6'h11, 1'b1, 32'h5555_0002);
      send(1'b1, q, 1'b1, {q[61:34], 32'hAAAA_0001, 32'h5555_0002}, 1'b0);
      idle();
      chk("b2b_occ", 96'(bus.OCC), 96'd0);

      // Collision on idx 0 with a different tag
      p = mk(11'h001, 7'h01, 4'b0001, 6'h02, 1'b0, 32'h1111_1111);
      send(1'b1, p, 1'b0, '0, 1'b0);
      chk("coll_store_occ", 96'(bus.OCC), 96'd1);
      q = mk(11'h000, 7'h00, 4'b0001, 6'h03, 1'b0, 32'h2222_2223);
      send(1'b1, q, 1'b1, {q[61:34], 32'h2222_2223, 31'd0, 1'b0}, 1'b1);
      idle();
      chk("coll_occ", 96'(bus.OCC), 96'd1);
      @(posedge CP);
      #1;

      // Backpressure with three monadic packets
      bus.Ack_in = 1'b0;
      fork
         begin
            p = mk(11'h100, 7'h10, 4'b0000, 6'h01, 1'b0, 32'h0000_0100);
            send(1'b1, p, 1'b1, {p[61:34], 32'h0000_0100, 32'd0}, 1'b0);
            p = mk(11'h200, 7'h20, 4'b0000, 6'h02, 1'b0, 32'h0000_0200);
            send(1'b1, p, 1'b1, {p[61:34], 32'h0000_0200, 32'd0}, 1'b0);
            p = mk(11'h300, 7'h30, 4'b0000, 6'h03, 1'b0, 32'h0000_0300);
            send(1'b1, p, 1'b1, {p[61:34], 32'h0000_0300, 32'd0}, 1'b0);
            idle();
         end
         begin
            int          w;
            logic [91:0] held;
            w = 0;
            while (!bus.Send_out && w < 20) begin
               @(negedge CP);
               w++;
            end
            held = bus.PACKET_OUT;
            chk("bp_captured", 96'(bus.Send_out), 96'd1);
            repeat (5) begin
               @(negedge CP);
               chk("bp_ack_out", 96'(bus.Ack_out), 96'd0);
               chk("bp_stable", 96'(bus.PACKET_OUT), 96'(held));
            end
            @(posedge CP);
            #1;
            bus.Ack_in = 1'b1;
         end
      join
      @(negedge CP);
      #1;
      chk("bp_drained", 96'(exp_q.size()), 96'd0);

      // Reset while an entry is stored and an output is held
      @(posedge CP);
      #1;
      bus.Ack_in = 1'b0;
      p = mk(11'h0F0, 7'h0E, 4'b0000, 6'h07, 1'b0, 32'hDEAD_BEEF);
      send(1'b1, p, 1'b0, '0, 1'b0);
      idle();
      chk("pre_rst_held", 96'(bus.Send_out), 96'd1);
      #2 MR = 1'b1;
      #1;
      chk("mr_send_out", 96'(bus.Send_out), 96'd0);
      chk("mr_retry", 96'(bus.RETRY), 96'd0);
      chk("mr_occ", 96'(bus.OCC), 96'd0);
      chk("mr_packet_out", 96'(bus.PACKET_OUT), 96'd0);
      chk("mr_ack_out", 96'(bus.Ack_out), 96'd0);
      MR = 1'b0;
      @(posedge CP);
      #1;
      chk("post_mr_ack_out", 96'(bus.Ack_out), 96'd1);
      bus.Ack_in = 1'b1;
      q = mk(11'h001, 7'h01, 4'b0001, 6'h02, 1'b1, 32'h3333_3333);
      send(1'b1, q, 1'b0, '0, 1'b0);
      idle();
      chk("post_mr_store_occ", 96'(bus.OCC), 96'd1);
      chk("post_mr_no_fire", 96'(bus.Send_out), 96'd0);

      repeat (3) @(posedge CP);
      #1;
      chk("final_queue_empty", 96'(exp_q.size()), 96'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/fc_stage.md
# fc_stage

Firing-control (operand matching) stage fed directly by the program-storage stage. It accepts 62-bit packets that carry the fetched instruction and drops absorbed packets. Monadic packets pass straight through. Dyadic operand pairs are held in a direct-mapped matching memory until their partner arrives, then emitted as one fired packet for the function-processing stage.

## Interface
Parameters:
- IDX_W, 4: matching-memory index width; depth = 2^IDX_W entries (16).

Ports:
- CP  in  1  clock, rising edge.
- MR  in  1  asynchronous, active-high reset.
- Send_in  in  1  upstream packet valid.
- DEL  in  1  upstream keep flag; 0 = packet is ABSORB and is discarded.
- PACKET_IN  in  62  upstream packet. Fields:
  - [61:51] CG (colour/generation).
  - [50:44] NXT (next destination).
  - [43:40] FLG; FLG[40] = 1 means dyadic.
  - [39:34] OPC.
  - [33] LR (0 left, 1 right).
  - [32] reserved.
  - [31:0] DATA.
- Ack_out  out  1  ready to upstream.
- Send_out  out  1  fired packet valid.
- Ack_in  in  1  downstream ready.
- PACKET_OUT  out  92  {TAG[91:64] = PACKET_IN[61:34], LDATA[63:32], RDATA[31:0]}.
- RETRY  out  1  qualifies Send_out: packet is a rejected operand for recirculation, not a fired instruction.
- OCC  out  IDX_W+1  number of valid matching-memory entries.

## Operation
- A transfer occurs on a CP rising edge with Send_in && Ack_out.
- Ack_out = !MR && (!Send_out || Ack_in). This is combinational; the output register is single-entry.
- TAG = PACKET_IN[61:34] (28 bits) is the match key.
- idx = PACKET_IN[54:51] ^ PACKET_IN[47:44]; for other IDX_W values, take the low IDX_W bits of CG XOR NXT.
- Each memory entry holds {V, TAG, LR, DATA}.
- On each accepted packet, exactly one of the following applies:
  - DEL = 0: packet is dropped. No output, no memory change.
  - Monadic (FLG[40] = 0): output loaded with {TAG, DATA, 32'd0}, RETRY = 0.
  - Dyadic, entry invalid: store {1, TAG, LR, DATA}. No output. OCC +1.
  - Dyadic, V && TAG match && stored LR != LR: fire.
    - LDATA = operand with LR = 0; RDATA = operand with LR = 1. The arrival order does not matter.
    - Entry is cleared; OCC -1.
    - RETRY = 0.
  - Dyadic, V && (TAG mismatch, or TAG match with the same LR): collision.
    - Output is loaded with {TAG, DATA, 31'd0, LR} and RETRY = 1.
    - The entry is unchanged.
- The output register holds its value while Send_out && !Ack_in.
- Send_out clears when the output is taken and no new output is loaded in the same cycle.
- Memory is a register array. A write on edge N is visible to the lookup for the packet accepted on edge N+1, so back-to-back packets to the same index match correctly.
- OCC never exceeds 2^IDX_W. A full memory has no special case: per-index collision handling covers it.

## Timing
- Latency: a packet accepted on edge N appears on Send_out/PACKET_OUT after edge N (one cycle), for the monadic, fire and collision cases.
- Throughput: one packet per cycle while Ack_in = 1.
- A simultaneous output drain and new load on the same edge is supported with no bubble.
- Reset values:
  - Send_out = 0, PACKET_OUT = 0, RETRY = 0, OCC = 0.
  - All V = 0.
  - Ack_out = 0 while MR = 1, and 1 on the first cycle after release.
- MR asserted mid-operation discards the held output and all stored operands immediately, without waiting for a clock.
- Send_in is ignored while Ack_out = 0. Upstream must hold the packet stable until it is accepted.

## Test plan
- Reset: pulse MR while an entry is held and Send_out = 1.
  - Send_out, RETRY, OCC and PACKET_OUT become 0 asynchronously.
  - A following right operand with the same tag is stored (OCC = 1), not fired.
- Monadic pass-through: FLG = 4'b0000, DATA = 32'h0000_0005, DEL = 1.
  - Next cycle: Send_out = 1, LDATA = 5, RDATA = 0, RETRY = 0.
  - A second packet with DEL = 0 produces no output.
- Pair, right first: R DATA = 32'd7, then L DATA = 32'd3, same TAG.
  - First packet: no output, OCC = 1.
  - Second packet: Send_out with LDATA = 3, RDATA = 7; OCC = 0.
- Collision: L operand with CG = 11'h001, NXT = 7'd1 is stored. Then send an L operand with CG = 11'h000, NXT = 7'd0 (same idx, 0).
  - Output has RETRY = 1, TAG of the second packet, RDATA[0] = 0.
  - OCC stays 1.
- Backpressure: hold Ack_in = 0 for 5 cycles with Send_in = 1 and three monadic packets queued.
  - One packet is captured; Ack_out = 0; PACKET_OUT is stable.
  - On release, the remaining packets are delivered one per cycle, in order.
- Back-to-back: L then R on the same tag on consecutive cycles.
  - The pair fires on the second acceptance; OCC returns to 0.
